// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, R-type functs, ALU operation codes
// and the per-instruction control bundle produced by the ID stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;

    typedef struct packed {
        logic       legal;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       aluimm;
        logic [3:0] aluc;
        logic       sext;
        logic       uses_rs;
        logic       uses_rt;
    } ctrl_t;

    // Baseline control for an I-type ALU instruction writing rt.
    function automatic ctrl_t i_ctrl(input logic [3:0] aluc, input logic sext);
        ctrl_t c;
        c         = '0;
        c.legal   = 1'b1;
        c.wreg    = 1'b1;
        c.aluimm  = 1'b1;
        c.aluc    = aluc;
        c.sext    = sext;
        c.uses_rs = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
        return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-through,
// one write port, async active-low clear, r0 hardwired to zero.
module regfile #(
    parameter int DEPTH = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] mem_q [DEPTH];

    // Register storage; writes to r0 are dropped.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (we && (wa != 5'd0)) begin
            mem_q[wa] <= wd;
        end
    end

    // Read ports; a same-cycle write to the read index bypasses the array.
    always_comb begin
        rd1 = 32'h0000_0000;
        rd2 = 32'h0000_0000;
        if (resetn) begin
            if (ra1 == 5'd0)                 rd1 = 32'h0000_0000;
            else if (we && (wa == ra1))      rd1 = wd;
            else                             rd1 = mem_q[ra1];
            if (ra2 == 5'd0)                 rd2 = 32'h0000_0000;
            else if (we && (wa == ra2))      rd2 = wd;
            else                             rd2 = mem_q[ra2];
        end else begin
            rd1 = 32'h0000_0000;
            rd2 = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, immediate extension,
// EXE/MEM operand forwarding, load-use stall with bubble injection.
module id_stage
    import mips_pkg::*;
#(
    parameter int RF_DEPTH = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] inst,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  edestReg,
    input  logic [31:0] ealu,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mdestReg,
    input  logic [31:0] malu,
    input  logic [31:0] mmo,
    input  logic        wwreg,
    input  logic [4:0]  wdestReg,
    input  logic [31:0] wdata,
    output logic        wreg,
    output logic        m2reg,
    output logic        wmem,
    output logic        aluimm,
    output logic [3:0]  aluc,
    output logic [4:0]  destReg,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] imm32,
    output logic        stall,
    output logic        illegal
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] rf_a_s;
    logic [31:0] rf_b_s;
    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;
    logic        stall_s;
    ctrl_t       ctrl_s;

    assign op_s    = inst[31:26];
    assign rs_s    = inst[25:21];
    assign rt_s    = inst[20:16];
    assign rd_s    = inst[15:11];
    assign funct_s = inst[5:0];

    regfile #(
        .DEPTH (RF_DEPTH)
    ) u_regfile (
        .clock  (clock),
        .resetn (resetn),
        .ra1    (rs_s),
        .ra2    (rt_s),
        .we     (wwreg),
        .wa     (wdestReg),
        .wd     (wdata),
        .rd1    (rf_a_s),
        .rd2    (rf_b_s)
    );

    // Main control decoder; anything unrecognised leaves ctrl_s all-zero (NOP).
    always_comb begin
        ctrl_s = '0;
        case (op_s)
            OP_RTYPE: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.wreg    = 1'b1;
                ctrl_s.uses_rs = 1'b1;
                ctrl_s.uses_rt = 1'b1;
                case (funct_s)
                    FN_ADD:  ctrl_s.aluc = ALUC_ADD;
                    FN_SUB:  ctrl_s.aluc = ALUC_SUB;
                    FN_AND:  ctrl_s.aluc = ALUC_AND;
                    FN_OR:   ctrl_s.aluc = ALUC_OR;
                    FN_XOR:  ctrl_s.aluc = ALUC_XOR;
                    default: ctrl_s = '0;
                endcase
            end
            OP_ADDI: ctrl_s = i_ctrl(ALUC_ADD, 1'b1);
            OP_ANDI: ctrl_s = i_ctrl(ALUC_AND, 1'b0);
            OP_ORI:  ctrl_s = i_ctrl(ALUC_OR,  1'b0);
            OP_XORI: ctrl_s = i_ctrl(ALUC_XOR, 1'b0);
            OP_LUI: begin
                ctrl_s         = i_ctrl(ALUC_LUI, 1'b0);
                ctrl_s.uses_rs = 1'b0;
            end
            OP_LW: begin
                ctrl_s       = i_ctrl(ALUC_ADD, 1'b1);
                ctrl_s.m2reg = 1'b1;
            end
            OP_SW: begin
                ctrl_s         = i_ctrl(ALUC_ADD, 1'b1);
                ctrl_s.wreg    = 1'b0;
                ctrl_s.wmem    = 1'b1;
                ctrl_s.uses_rt = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Operand selection: EXE beats MEM beats the register file; r0 never forwards.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0)                                   return 32'h0000_0000;
        else if (ewreg && !em2reg && (edestReg == idx))    return ealu;
        else if (mwreg && !mm2reg && (mdestReg == idx))    return malu;
        else if (mwreg &&  mm2reg && (mdestReg == idx))    return mmo;
        else                                               return rf;
    endfunction

    assign fwd_a_s = fwd(rs_s, rf_a_s);
    assign fwd_b_s = fwd(rt_s, rf_b_s);

    assign stall_s = ewreg && em2reg && (edestReg != 5'd0) &&
                     (((edestReg == rs_s) && ctrl_s.uses_rs) ||
                      ((edestReg == rt_s) && ctrl_s.uses_rt));

    // Output stage: everything is held at zero in reset; a stall kills the writes.
    always_comb begin
        wreg    = 1'b0;
        m2reg   = 1'b0;
        wmem    = 1'b0;
        aluimm  = 1'b0;
        aluc    = 4'b0000;
        destReg = 5'd0;
        qa      = 32'h0000_0000;
        qb      = 32'h0000_0000;
        imm32   = 32'h0000_0000;
        stall   = 1'b0;
        illegal = 1'b0;
        if (resetn) begin
            wreg    = ctrl_s.wreg && !stall_s;
            m2reg   = ctrl_s.m2reg;
            wmem    = ctrl_s.wmem && !stall_s;
            aluimm  = ctrl_s.aluimm;
            aluc    = ctrl_s.aluc;
            destReg = (op_s == OP_RTYPE) ? rd_s : rt_s;
            qa      = fwd_a_s;
            qb      = fwd_b_s;
            imm32   = ext_imm(inst[15:0], ctrl_s.sext);
            stall   = stall_s;
            illegal = !ctrl_s.legal;
        end else begin
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized decode
// compared against a mnemonic-level reference model with its own register array.
module tb_id_stage;

    logic        clock;
    logic        resetn;
    logic [31:0] inst;
    logic        ewreg, em2reg, mwreg, mm2reg, wwreg;
    logic [4:0]  edestReg, mdestReg, wdestReg;
    logic [31:0] ealu, malu, mmo, wdata;
    logic        wreg, m2reg, wmem, aluimm, stall, illegal;
    logic [3:0]  aluc;
    logic [4:0]  destReg;
    logic [31:0] qa, qb, imm32;
    logic [110:0] obs;

    int errors = 0;
    int checks = 0;
    logic [31:0] regs [32];

    localparam int M_ILL = 0, M_ADD = 1, M_SUB = 2, M_AND = 3, M_OR = 4, M_XOR = 5,
                   M_ADDI = 6, M_ANDI = 7, M_ORI = 8, M_XORI = 9, M_LUI = 10,
                   M_LW = 11, M_SW = 12;

    id_stage dut (
        .clock(clock), .resetn(resetn), .inst(inst),
        .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg), .ealu(ealu),
        .mwreg(mwreg), .mm2reg(mm2reg), .mdestReg(mdestReg), .malu(malu), .mmo(mmo),
        .wwreg(wwreg), .wdestReg(wdestReg), .wdata(wdata),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .aluc(aluc),
        .destReg(destReg), .qa(qa), .qb(qb), .imm32(imm32),
        .stall(stall), .illegal(illegal)
    );

    assign obs = {wreg, m2reg, wmem, aluimm, aluc, destReg, qa, qb, imm32, stall, illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] r_inst(input logic [5:0] fn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic int mnemonic(input logic [31:0] ins);
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: return M_ADD;
                6'h22: return M_SUB;
                6'h24: return M_AND;
                6'h25: return M_OR;
                6'h26: return M_XOR;
                default: return M_ILL;
            endcase
        end
        case (ins[31:26])
            6'h08: return M_ADDI;
            6'h0C: return M_ANDI;
            6'h0D: return M_ORI;
            6'h0E: return M_XORI;
            6'h0F: return M_LUI;
            6'h23: return M_LW;
            6'h2B: return M_SW;
            default: return M_ILL;
        endcase
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (ewreg && !em2reg && edestReg == idx) return ealu;
        if (mwreg && !mm2reg && mdestReg == idx) return malu;
        if (mwreg && mm2reg && mdestReg == idx) return mmo;
        if (wwreg && wdestReg == idx) return wdata;
        return regs[idx];
    endfunction

    // Reference: expected output vector plus a mask of the fields the rules define.
    task automatic model(output logic [110:0] exp, output logic [110:0] mask);
        int m;
        logic legal, rtype, st, urs, urt, stl, sx;
        logic [3:0] alu;
        logic [4:0] rs, rt;
        mask = '1;
        if (!resetn) begin
            exp = '0;
            return;
        end
        m = mnemonic(inst);
        rs = inst[25:21];
        rt = inst[20:16];
        legal = (m != M_ILL);
        rtype = (inst[31:26] == 6'h00);
        st = (m == M_SW);
        urs = legal && (m != M_LUI);
        urt = (legal && rtype) || st;
        case (m)
            M_SUB:           alu = 4'b0100;
            M_AND, M_ANDI:   alu = 4'b0001;
            M_OR, M_ORI:     alu = 4'b0101;
            M_XOR, M_XORI:   alu = 4'b0010;
            M_LUI:           alu = 4'b0110;
            default:         alu = 4'b0000;
        endcase
        sx = (m == M_ADDI) || (m == M_LW) || (m == M_SW);
        stl = ewreg && em2reg && (edestReg != 5'd0) &&
              ((edestReg == rs && urs) || (edestReg == rt && urt));
        exp = {legal && !st && !stl, m == M_LW, st && !stl, legal && !rtype, alu,
               rtype ? inst[15:11] : rt, operand(rs), operand(rt),
               sx ? {{16{inst[15]}}, inst[15:0]} : {16'h0000, inst[15:0]},
               stl, !legal};
        if (rtype || !legal) mask[33:2] = '0;
        if (!legal) mask[107:98] = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (resetn && wwreg && wdestReg != 5'd0) regs[wdestReg] = wdata;
        #1;
    endtask

    task automatic clear_fwd();
        ewreg = 1'b0; em2reg = 1'b0; edestReg = 5'd0; ealu = 32'h0;
        mwreg = 1'b0; mm2reg = 1'b0; mdestReg = 5'd0; malu = 32'h0; mmo = 32'h0;
        wwreg = 1'b0; wdestReg = 5'd0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        inst = r_inst(6'h20, 5'd2, 5'd3, 5'd4);
        ewreg = 1'b1; edestReg = 5'd2; ealu = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (obs !== 111'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        tick();
        clear_fwd();
        #2;
        resetn = 1'b1;
        #1;
        checks++;
        if (qa !== 32'h0 || qb !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: qa=%h qb=%h, want 0", qa, qb);
        end
    endtask

    task automatic test_rf_write();
        tick();
        wwreg = 1'b1; wdestReg = 5'd5; wdata = 32'h0000_1234;
        inst = 32'h0;
        tick();
        wwreg = 1'b0;
        inst = r_inst(6'h20, 5'd5, 5'd0, 5'd3);
        #1;
        checks++;
        if (qa !== 32'h0000_1234 || qb !== 32'h0 || destReg !== 5'd3 || wreg !== 1'b1 || aluc !== 4'b0000) begin
            errors++;
            $display("FAIL rf_write: qa=%h qb=%h dest=%0d wreg=%b aluc=%b, want 1234 0 3 1 0000",
                     qa, qb, destReg, wreg, aluc);
        end
        wwreg = 1'b1; wdestReg = 5'd0; wdata = 32'h0000_1234;
        tick();
        wwreg = 1'b0;
        inst = r_inst(6'h20, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (qa !== 32'h0 || qb !== 32'h0) begin
            errors++;
            $display("FAIL r0_write: qa=%h qb=%h, want 0", qa, qb);
        end
    endtask

    task automatic test_write_through();
        wwreg = 1'b1; wdestReg = 5'd7; wdata = 32'hAAAA_5555;
        inst = r_inst(6'h25, 5'd7, 5'd7, 5'd1);
        #1;
        checks++;
        if (qa !== 32'hAAAA_5555 || qb !== 32'hAAAA_5555 || aluc !== 4'b0101) begin
            errors++;
            $display("FAIL write_through: qa=%h qb=%h aluc=%b, want aaaa5555 x2 0101", qa, qb, aluc);
        end
        tick();
        wwreg = 1'b0; wdata = 32'h0;
        #1;
        checks++;
        if (qa !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL write_persist: qa=%h, want aaaa5555", qa);
        end
    endtask

    task automatic test_fwd_priority();
        ewreg = 1'b1; em2reg = 1'b0; edestReg = 5'd4; ealu = 32'h10;
        mwreg = 1'b1; mm2reg = 1'b0; mdestReg = 5'd4; malu = 32'h20;
        inst = r_inst(6'h22, 5'd4, 5'd4, 5'd2);
        #1;
        checks++;
        if (qa !== 32'h10 || qb !== 32'h10 || aluc !== 4'b0100) begin
            errors++;
            $display("FAIL fwd_exe_first: qa=%h qb=%h aluc=%b, want 10 10 0100", qa, qb, aluc);
        end
        ewreg = 1'b0;
        wwreg = 1'b1; wdestReg = 5'd4; wdata = 32'h30;
        #1;
        checks++;
        if (qa !== 32'h20 || qb !== 32'h20) begin
            errors++;
            $display("FAIL fwd_mem_over_wb: qa=%h qb=%h, want 20 20", qa, qb);
        end
        tick();
        clear_fwd();
    endtask

    task automatic test_load_use();
        ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd8;
        inst = r_inst(6'h20, 5'd8, 5'd1, 5'd9);
        #1;
        checks++;
        if (stall !== 1'b1 || wreg !== 1'b0 || wmem !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b wreg=%b wmem=%b, want 1 0 0", stall, wreg, wmem);
        end
        tick();
        ewreg = 1'b0; em2reg = 1'b0; edestReg = 5'd0;
        mwreg = 1'b1; mm2reg = 1'b1; mdestReg = 5'd8; mmo = 32'hCAFE; malu = 32'h1111;
        #1;
        checks++;
        if (stall !== 1'b0 || qa !== 32'hCAFE || wreg !== 1'b1) begin
            errors++;
            $display("FAIL load_use_fwd: stall=%b qa=%h wreg=%b, want 0 cafe 1", stall, qa, wreg);
        end
        clear_fwd();
        ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd8;
        inst = i_inst(6'h2B, 5'd1, 5'd8, 16'h0004);
        #1;
        checks++;
        if (stall !== 1'b1 || wmem !== 1'b0) begin
            errors++;
            $display("FAIL sw_rt_stall: stall=%b wmem=%b, want 1 0", stall, wmem);
        end
        clear_fwd();
        tick();
    endtask

    task automatic test_imm();
        inst = i_inst(6'h08, 5'd1, 5'd2, 16'hFFFF);
        #1;
        checks++;
        if (imm32 !== 32'hFFFF_FFFF || aluc !== 4'b0000 || aluimm !== 1'b1 || destReg !== 5'd2) begin
            errors++;
            $display("FAIL addi_sext: imm=%h aluc=%b aluimm=%b dest=%0d, want ffffffff 0000 1 2",
                     imm32, aluc, aluimm, destReg);
        end
        inst = i_inst(6'h0D, 5'd1, 5'd2, 16'hFFFF);
        #1;
        checks++;
        if (imm32 !== 32'h0000_FFFF || aluc !== 4'b0101) begin
            errors++;
            $display("FAIL ori_zext: imm=%h aluc=%b, want 0000ffff 0101", imm32, aluc);
        end
        ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd8;
        inst = i_inst(6'h0F, 5'd8, 5'd3, 16'h1234);
        #1;
        checks++;
        if (aluc !== 4'b0110 || stall !== 1'b0 || wreg !== 1'b1) begin
            errors++;
            $display("FAIL lui_nostall: aluc=%b stall=%b wreg=%b, want 0110 0 1", aluc, stall, wreg);
        end
        inst = i_inst(6'h23, 5'd2, 5'd9, 16'h8000);
        #1;
        checks++;
        if (m2reg !== 1'b1 || imm32 !== 32'hFFFF_8000 || wmem !== 1'b0 || wreg !== 1'b1) begin
            errors++;
            $display("FAIL lw_ctrl: m2reg=%b imm=%h wmem=%b wreg=%b, want 1 ffff8000 0 1",
                     m2reg, imm32, wmem, wreg);
        end
        clear_fwd();
    endtask

    task automatic test_illegal();
        inst = i_inst(6'h3F, 5'd1, 5'd2, 16'h0000);
        #1;
        checks++;
        if (illegal !== 1'b1 || wreg !== 1'b0 || wmem !== 1'b0 || m2reg !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op: illegal=%b wreg=%b wmem=%b m2reg=%b, want 1 0 0 0",
                     illegal, wreg, wmem, m2reg);
        end
        inst = r_inst(6'h27, 5'd1, 5'd2, 5'd3);
        #1;
        checks++;
        if (illegal !== 1'b1 || wreg !== 1'b0) begin
            errors++;
            $display("FAIL illegal_funct: illegal=%b wreg=%b, want 1 0", illegal, wreg);
        end
    endtask

    task automatic test_reset_mid();
        wwreg = 1'b1; wdestReg = 5'd6; wdata = 32'h55;
        tick();
        wdata = 32'h77;
        #1;
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        inst = r_inst(6'h20, 5'd6, 5'd5, 5'd1);
        #1;
        checks++;
        if (obs !== 111'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, want 0", obs);
        end
        tick();
        wwreg = 1'b0;
        #1;
        resetn = 1'b1;
        #1;
        checks++;
        if (qa !== 32'h0 || qb !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_regs: qa=%h qb=%h, want 0 0", qa, qb);
        end
    endtask

    task automatic test_random();
        logic [110:0] exp, mask;
        logic [5:0] iops [7];
        logic [5:0] fns [5];
        int k;
        iops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 12);
            if (k < 5)
                inst = r_inst(fns[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)));
            else if (k < 12)
                inst = i_inst(iops[k-5], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              16'($urandom));
            else
                inst = {6'h3F, 26'($urandom)};
            ewreg = 1'($urandom); em2reg = 1'($urandom); edestReg = 5'($urandom_range(0, 7));
            ealu = $urandom;
            mwreg = 1'($urandom); mm2reg = 1'($urandom); mdestReg = 5'($urandom_range(0, 7));
            malu = $urandom; mmo = $urandom;
            wwreg = 1'($urandom); wdestReg = 5'($urandom_range(0, 7)); wdata = $urandom;
            #1;
            model(exp, mask);
            checks++;
            if ((obs & mask) !== (exp & mask)) begin
                errors++;
                $display("FAIL random[%0d] inst=%h: got %h, want %h (mask %h)", n, inst,
                         obs & mask, exp & mask, mask);
            end
            tick();
        end
        clear_fwd();
    endtask

    initial begin
        resetn = 1'b0;
        inst = 32'h0;
        clear_fwd();
        test_reset();
        test_rf_write();
        test_write_through();
        test_fwd_priority();
        test_load_use();
        test_imm();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It sits between the IF/ID register and the ID/EXE pipeline register, and produces exactly the signal set that register captures: wreg, m2reg, wmem, aluc, aluimm, destReg, qa, qb and imm32. It contains the 32×32 register file, the main control decoder, immediate extension, EXE/MEM→ID operand forwarding and load-use hazard detection. On a load-use hazard it stalls the front end and injects a bubble.

## Interface
Parameters
- RF_DEPTH, 32, number of architectural registers; r0 is hardwired to zero.

Ports
- clock  in  1  pipeline clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst  in  32  instruction from the IF/ID register.
- ewreg, em2reg  in  1 each  write-enable and load flag of the instruction in EXE.
- edestReg  in  5  destination register of the instruction in EXE.
- ealu  in  32  ALU result in EXE.
- mwreg, mm2reg  in  1 each  write-enable and load flag of the instruction in MEM.
- mdestReg  in  5  destination register of the instruction in MEM.
- malu  in  32  ALU result held in MEM.
- mmo  in  32  data-memory read data in MEM.
- wwreg  in  1  write-back enable.
- wdestReg  in  5  write-back register index.
- wdata  in  32  write-back data.
- wreg, m2reg, wmem, aluimm  out  1 each  control to ID/EXE.
- aluc  out  4  ALU operation code.
- destReg  out  5  rd for R-type, rt for I-type.
- qa, qb  out  32  forwarded rs/rt operands.
- imm32  out  32  extended immediate.
- stall  out  1  high: hold PC and IF/ID.
- illegal  out  1  high: unsupported opcode/funct (decoded as a NOP).

## Operation
- Supported instructions:
  - R-type (op 0) by funct: add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26.
  - I-type by op: addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B.
- aluc codes: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110 (result = b<<16). lw and sw use add.
- Immediate extension:
  - Sign-extend for addi, lw, sw.
  - Zero-extend for andi, ori, xori, lui.
- aluimm = 1 for all I-type instructions.
- Control outputs: wreg = 1 for all supported instructions except sw; m2reg = 1 only for lw; wmem = 1 only for sw.
- Illegal instructions: illegal = 1; wreg = wmem = m2reg = 0.
- Register file:
  - Write on a clock edge when wwreg = 1 and wdestReg ≠ 0.
  - Reads are combinational with write-through: a same-cycle write to the read index returns wdata.
  - Index 0 always reads 0.
- Forwarding for qa (index rs) and qb (index rt), first match wins; any index 0 never forwards:
  - ealu, if ewreg & !em2reg & edestReg == idx.
  - malu, if mwreg & !mm2reg & mdestReg == idx.
  - mmo, if mwreg & mm2reg & mdestReg == idx.
  - Otherwise, the register-file read.
- Load-use stall: stall = ewreg & em2reg & edestReg ≠ 0 & ((edestReg == rs & usesRs) | (edestReg == rt & usesRt)).
  - usesRs = 1 for every supported instruction except lui.
  - usesRt = 1 for R-type and sw.
- Bubble: while stall = 1, wreg and wmem are forced to 0. All other outputs keep their decoded values.

## Timing
- All outputs are combinational from inst, the forwarding inputs and register-file state. Decode latency is 0 cycles; the ID/EXE register provides the one-cycle boundary.
- A register-file write becomes visible in the same cycle through write-through, and from register state on the next cycle.
- A load immediately followed by a dependent instruction gives exactly 1 stall cycle. On the next cycle the result comes from mmo via forwarding.
- While resetn = 0:
  - All registers read 0.
  - stall = 0, illegal = 0.
  - wreg = m2reg = wmem = aluimm = 0, aluc = 0, destReg = 0, qa = qb = imm32 = 0.
- Reset assertion mid-write discards the write. Deassertion takes effect at the next clock edge.
- Simultaneous events:
  - EXE and MEM both targeting the same register: EXE has priority.
  - WB writing a register while MEM also targets it: MEM has priority.

## Structure
- Shared package mips_pkg holds the opcode constants, funct constants and aluc codes; the EXE stage imports the same aluc codes.
- One sub-module: regfile (2 read ports, 1 write port, async active-low clear, write-through).
- Control decode, forwarding muxes and hazard logic live in id_stage.

## Test plan
- Reset, then write wdata = 0x1234 to r5 via WB, then decode add r3,r5,r0 -> qa = 0x1234; same test with r0 as destination -> r0 still reads 0.
- Same-cycle WB write of 0xAAAA5555 to r7 while decoding or r1,r7,r7 -> qa = qb = 0xAAAA5555 in that cycle.
- EXE and MEM both targeting r4 (ealu = 0x10, malu = 0x20), decode sub r2,r4,r4 -> qa = qb = 0x10; remove EXE match -> 0x20.
- lw r8 in EXE, decode add r9,r8,r1 -> stall = 1, wreg = wmem = 0; next cycle with lw in MEM and mmo = 0xCAFE -> stall = 0, qa = 0xCAFE.
- addi with imm 0xFFFF -> imm32 = 0xFFFFFFFF, aluc = 0000; ori with imm 0xFFFF -> imm32 = 0x0000FFFF, aluc = 0101; lui -> aluc = 0110, no stall even when its rs matches a pending load.
- Opcode 0x3F -> illegal = 1, wreg = wmem = 0; assert resetn low mid-sequence -> all outputs 0 and registers cleared.
